// File: rtl/rvee_dmem_if.sv
// AXI4-lite interface bundle between the load/store unit master and the data memory.
// Address width AWIDTH, data width DWIDTH, byte strobes DWIDTH/8.
interface axi4lite_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) ();
  logic                  awvalid;
  logic                  awready;
  logic [AWIDTH-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DWIDTH-1:0]     wdata;
  logic [DWIDTH/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [AWIDTH-1:0]     araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DWIDTH-1:0]     rdata;
  logic [1:0]            rresp;

  modport master_port (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slave_port (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/rvee_dmem.sv
// AXI4-lite word-addressed data memory slave with byte strobes and a one-deep read pipeline.
// Define RVEE_CONFIG_DMEM_ERR_EN to answer out-of-range addresses with SLVERR instead of wrapping.
module rvee_dmem #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  axi4lite_if.slave_port axi_if
);
  localparam int         IDXW        = $clog2(DEPTH);
  localparam int         NB          = DWIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic addr_oob(input logic [AWIDTH-1:0] addr);
`ifdef RVEE_CONFIG_DMEM_ERR_EN
    addr_oob = (addr >> (IDXW + 2)) != {AWIDTH{1'b0}};
`else
    addr_oob = (^addr) & 1'b0;
`endif
  endfunction

  logic [DWIDTH-1:0] r_mem [DEPTH];

  logic              r_aw_held;
  logic [IDXW-1:0]   r_aw_idx;
  logic              r_aw_err;
  logic              r_w_held;
  logic [DWIDTH-1:0] r_w_data;
  logic [NB-1:0]     r_w_strb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_rvalid;
  logic [DWIDTH-1:0] r_rdata;
  logic [1:0]        r_rresp;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_ar_hs;
  logic              w_arready;
  logic              w_wr_fire;
  logic              w_ar_err;
  logic [IDXW-1:0]   w_ar_idx;
  logic              w_unused_bits;

  assign w_aw_hs   = axi_if.awvalid & ~r_aw_held;
  assign w_w_hs    = axi_if.wvalid & ~r_w_held;
  assign w_arready = ~r_rvalid | axi_if.rready;
  assign w_ar_hs   = axi_if.arvalid & w_arready;
  assign w_ar_idx  = axi_if.araddr[IDXW+1:2];
  assign w_ar_err  = addr_oob(axi_if.araddr);
  // A write commits only once the previous response has left, so B never gets overwritten.
  assign w_wr_fire = r_aw_held & r_w_held & ~r_bvalid;

  assign axi_if.awready = ~r_aw_held;
  assign axi_if.wready  = ~r_w_held;
  assign axi_if.bvalid  = r_bvalid;
  assign axi_if.bresp   = r_bresp;
  assign axi_if.arready = w_arready;
  assign axi_if.rvalid  = r_rvalid;
  assign axi_if.rdata   = r_rdata;
  assign axi_if.rresp   = r_rresp;

  assign w_unused_bits = ^{axi_if.awprot, axi_if.arprot, axi_if.awaddr, axi_if.araddr};

  // AW holding register: captures index and range error at handshake, frees on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= {IDXW{1'b0}};
      r_aw_err  <= 1'b0;
    end else if (w_aw_hs) begin
      r_aw_held <= 1'b1;
      r_aw_idx  <= axi_if.awaddr[IDXW+1:2];
      r_aw_err  <= addr_oob(axi_if.awaddr);
    end else if (w_wr_fire) begin
      r_aw_held <= 1'b0;
    end else begin
      r_aw_held <= r_aw_held;
    end
  end

  // W holding register: data and strobes wait here for a matching address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_held <= 1'b0;
      r_w_data <= {DWIDTH{1'b0}};
      r_w_strb <= {NB{1'b0}};
    end else if (w_w_hs) begin
      r_w_held <= 1'b1;
      r_w_data <= axi_if.wdata;
      r_w_strb <= axi_if.wstrb;
    end else if (w_wr_fire) begin
      r_w_held <= 1'b0;
    end else begin
      r_w_held <= r_w_held;
    end
  end

  // Write response channel: raised on commit, held until the master takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_wr_fire) begin
      r_bvalid <= 1'b1;
      r_bresp  <= r_aw_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_bvalid && axi_if.bready) begin
      r_bvalid <= 1'b0;
    end else begin
      r_bvalid <= r_bvalid;
    end
  end

  // Read data channel: the array read here sees pre-write contents on a colliding edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= {DWIDTH{1'b0}};
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_err ? {DWIDTH{1'b0}} : r_mem[w_ar_idx];
      r_rresp  <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
    end else if (axi_if.rready) begin
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= r_rvalid;
    end
  end

  // Storage array: byte-lane merge of the held write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_fire && !r_aw_err) begin
      for (int b = 0; b < NB; b++) begin
        if (r_w_strb[b]) begin
          r_mem[r_aw_idx][8*b +: 8] <= r_w_data[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_rvee_dmem.sv
// Self-checking bench for rvee_dmem: directed scenarios plus randomized AXI traffic
// compared every cycle against a queue/array reference model of the memory slave.
module tb_rvee_dmem;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4lite_if #(.AWIDTH(32), .DWIDTH(32)) axi_if ();

  rvee_dmem #(.AWIDTH(32), .DWIDTH(32), .DEPTH(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axi_if(axi_if)
  );

  int errors = 0;
  int checks = 0;
  int dut_b  = 0;

  // Reference model: word array with per-byte "known" flags, queues for pending AW/W.
  logic [31:0] mem_m   [1024];
  logic [3:0]  known_m [1024];
  logic [31:0] aw_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  bit          m_bvalid;
  logic [1:0]  m_bresp;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  logic [3:0]  m_rmask;
  logic [1:0]  m_rresp;
  bit          aw_acc, w_acc, ar_acc;

  function automatic bit oob(input logic [31:0] a);
`ifdef RVEE_CONFIG_DMEM_ERR_EN
    return a >= 32'd4096;
`else
    return (a == a) ? 1'b0 : 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  function automatic logic [31:0] bm(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic model_reset();
    aw_q.delete(); wd_q.delete(); ws_q.delete();
    m_bvalid = 1'b0; m_bresp = 2'b00;
    m_rvalid = 1'b0; m_rresp = 2'b00;
    aw_acc = 1'b0; w_acc = 1'b0; ar_acc = 1'b0;
  endtask

  task automatic model_step();
    bit aw_hs, w_hs, ar_hs;
    logic [31:0] a, d;
    logic [3:0] s;
    int i;
    aw_hs = axi_if.awvalid && (aw_q.size() == 0);
    w_hs  = axi_if.wvalid && (wd_q.size() == 0);
    ar_hs = axi_if.arvalid && (!m_rvalid || axi_if.rready);
    if (ar_hs) begin
      if (oob(axi_if.araddr)) begin
        m_rdata = 32'd0; m_rmask = 4'hF; m_rresp = 2'b10;
      end else begin
        m_rdata = mem_m[widx(axi_if.araddr)];
        m_rmask = known_m[widx(axi_if.araddr)];
        m_rresp = 2'b00;
      end
      m_rvalid = 1'b1;
    end else if (axi_if.rready) begin
      m_rvalid = 1'b0;
    end
    if (aw_q.size() == 1 && wd_q.size() == 1 && !m_bvalid) begin
      a = aw_q.pop_front(); d = wd_q.pop_front(); s = ws_q.pop_front();
      i = widx(a);
      if (!oob(a)) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) begin
            mem_m[i][8*b +: 8] = d[8*b +: 8];
            known_m[i][b] = 1'b1;
          end
        end
      end
      m_bvalid = 1'b1;
      m_bresp  = oob(a) ? 2'b10 : 2'b00;
    end else if (m_bvalid && axi_if.bready) begin
      m_bvalid = 1'b0;
    end
    if (aw_hs) aw_q.push_back(axi_if.awaddr);
    if (w_hs) begin
      wd_q.push_back(axi_if.wdata);
      ws_q.push_back(axi_if.wstrb);
    end
    aw_acc = aw_hs; w_acc = w_hs; ar_acc = ar_hs;
  endtask

  task automatic compare();
    check1("awready", axi_if.awready, aw_q.size() == 0);
    check1("wready", axi_if.wready, wd_q.size() == 0);
    check1("arready", axi_if.arready, !m_rvalid || axi_if.rready);
    check1("bvalid", axi_if.bvalid, m_bvalid);
    if (m_bvalid) check32("bresp", {30'd0, axi_if.bresp}, {30'd0, m_bresp});
    check1("rvalid", axi_if.rvalid, m_rvalid);
    if (m_rvalid) begin
      check32("rresp", {30'd0, axi_if.rresp}, {30'd0, m_rresp});
      check32("rdata", axi_if.rdata & bm(m_rmask), m_rdata & bm(m_rmask));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (axi_if.bvalid && axi_if.bready) dut_b++;
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    axi_if.awvalid = 1'b1; axi_if.awaddr = a;
    axi_if.wvalid  = 1'b1; axi_if.wdata  = d; axi_if.wstrb = s;
    axi_if.bready  = 1'b1;
    cycle();
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    axi_if.arvalid = 1'b1; axi_if.araddr = a; axi_if.rready = 1'b1;
    cycle();
    axi_if.arvalid = 1'b0;
    check1({name, "_rvalid"}, axi_if.rvalid, 1'b1);
    check32(name, axi_if.rdata, exp);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h200 | ({28'd0, 4'($urandom_range(0, 15))} << 2) | {30'd0, 2'($urandom_range(0, 3))};
    if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_F000);
    return a;
  endfunction

  logic [31:0] v0, v1, v2;
  int          b0;

  initial begin
    for (int i = 0; i < 1024; i++) known_m[i] = 4'h0;
    model_reset();
    axi_if.awvalid = 1'b0; axi_if.awaddr = 32'd0; axi_if.awprot = 3'd0;
    axi_if.wvalid  = 1'b0; axi_if.wdata  = 32'd0; axi_if.wstrb  = 4'd0;
    axi_if.bready  = 1'b1;
    axi_if.arvalid = 1'b0; axi_if.araddr = 32'd0; axi_if.arprot = 3'd0;
    axi_if.rready  = 1'b1;
    #1;
    check1("rst_awready", axi_if.awready, 1'b1);
    check1("rst_wready", axi_if.wready, 1'b1);
    check1("rst_arready", axi_if.arready, 1'b1);
    check1("rst_bvalid", axi_if.bvalid, 1'b0);
    check1("rst_rvalid", axi_if.rvalid, 1'b0);
    check32("rst_bresp", {30'd0, axi_if.bresp}, 32'd0);
    check32("rst_rresp", {30'd0, axi_if.rresp}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check1("rst_release_bvalid", axi_if.bvalid, 1'b0);

    // Full-word write, exact 2-edge write latency, read back.
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h100;
    axi_if.wvalid  = 1'b1; axi_if.wdata  = 32'hDEADBEEF; axi_if.wstrb = 4'hF;
    cycle();
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    check1("wlat_edge1_bvalid", axi_if.bvalid, 1'b0);
    cycle();
    check1("wlat_edge2_bvalid", axi_if.bvalid, 1'b1);
    check32("wlat_bresp", {30'd0, axi_if.bresp}, 32'd0);
    cycle();
    rd("rd_0x100", 32'h100, 32'hDEADBEEF);
    cycle();

    // W ahead of AW, strobed merge.
    wr(32'h104, 32'hFFFFFFFF, 4'hF);
    b0 = dut_b;
    axi_if.wvalid = 1'b1; axi_if.wdata = 32'h11223344; axi_if.wstrb = 4'b0101;
    cycle();
    axi_if.wvalid = 1'b0;
    check1("w_early_wready", axi_if.wready, 1'b0);
    cycle();
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h104;
    cycle();
    axi_if.awvalid = 1'b0;
    cycle();
    check1("w_early_bvalid", axi_if.bvalid, 1'b1);
    repeat (3) cycle();
    check32("w_early_single_b", dut_b - b0, 32'd1);
    rd("rd_0x104_merge", 32'h104, 32'hFF22FF44);
    cycle();

    // Back-pressured B with a second write parked in the holding registers.
    axi_if.bready  = 1'b0;
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h108;
    axi_if.wvalid  = 1'b1; axi_if.wdata  = 32'h0BADF00D; axi_if.wstrb = 4'hF;
    cycle();
    axi_if.awaddr = 32'h10C; axi_if.wdata = 32'h12345678;
    cycle();
    cycle();
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    check1("bp_awready", axi_if.awready, 1'b0);
    check1("bp_wready", axi_if.wready, 1'b0);
    repeat (3) begin
      cycle();
      check1("bp_bvalid_hold", axi_if.bvalid, 1'b1);
      check32("bp_bresp_hold", {30'd0, axi_if.bresp}, 32'd0);
    end
    axi_if.bready = 1'b1;
    cycle();
    check1("bp_first_b_done", axi_if.bvalid, 1'b0);
    cycle();
    check1("bp_second_b", axi_if.bvalid, 1'b1);
    cycle();
    rd("rd_0x10C", 32'h10C, 32'h12345678);
    rd("rd_0x108", 32'h108, 32'h0BADF00D);
    cycle();

    // Back-to-back reads, then R back-pressure.
    v0 = 32'hA0A0_0001; v1 = 32'hB1B1_0002; v2 = 32'hC2C2_0003;
    wr(32'h0, v0, 4'hF); wr(32'h4, v1, 4'hF); wr(32'h8, v2, 4'hF);
    axi_if.arvalid = 1'b1; axi_if.araddr = 32'h0; axi_if.rready = 1'b1;
    cycle();
    check32("b2b_rd0", axi_if.rdata, v0);
    check1("b2b_arready0", axi_if.arready, 1'b1);
    axi_if.araddr = 32'h4;
    cycle();
    check32("b2b_rd1", axi_if.rdata, v1);
    check1("b2b_rvalid1", axi_if.rvalid, 1'b1);
    axi_if.araddr = 32'h8;
    cycle();
    check32("b2b_rd2", axi_if.rdata, v2);
    axi_if.arvalid = 1'b0;
    axi_if.rready  = 1'b0;
    #1 check1("rstall_arready", axi_if.arready, 1'b0);
    cycle();
    check1("rstall_rvalid", axi_if.rvalid, 1'b1);
    check32("rstall_rdata", axi_if.rdata, v2);
    axi_if.rready = 1'b1;
    cycle();

    // Read and write committing on the same edge to the same word.
    wr(32'h20, 32'h0, 4'hF);
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h20;
    axi_if.wvalid  = 1'b1; axi_if.wdata  = 32'hA5A5A5A5; axi_if.wstrb = 4'hF;
    cycle();
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    axi_if.arvalid = 1'b1; axi_if.araddr = 32'h20;
    cycle();
    axi_if.arvalid = 1'b0;
    check32("same_edge_old", axi_if.rdata, 32'h0);
    cycle();
    rd("same_edge_new", 32'h20, 32'hA5A5A5A5);
    cycle();

    // Out-of-range read.
    axi_if.arvalid = 1'b1; axi_if.araddr = 32'h1000;
    cycle();
    axi_if.arvalid = 1'b0;
`ifdef RVEE_CONFIG_DMEM_ERR_EN
    check32("oob_rresp", {30'd0, axi_if.rresp}, 32'd2);
    check32("oob_rdata", axi_if.rdata, 32'd0);
`else
    check32("oob_rresp", {30'd0, axi_if.rresp}, 32'd0);
    check32("oob_rdata", axi_if.rdata, v0);
`endif
    cycle();

    // Asynchronous reset with a B pending and a write parked.
    wr(32'h34, 32'h5A5A0000, 4'hF);
    axi_if.bready  = 1'b0;
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h30;
    axi_if.wvalid  = 1'b1; axi_if.wdata  = 32'h77777777; axi_if.wstrb = 4'hF;
    cycle();
    axi_if.awaddr = 32'h34; axi_if.wdata = 32'h99999999;
    cycle();
    cycle();
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    check1("pre_rst_bvalid", axi_if.bvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("async_rst_bvalid", axi_if.bvalid, 1'b0);
    check1("async_rst_awready", axi_if.awready, 1'b1);
    check1("async_rst_wready", axi_if.wready, 1'b0 == 1'b0);
    rst_n = 1'b1;
    model_reset();
    #1 check1("post_rst_bvalid", axi_if.bvalid, 1'b0);
    axi_if.bready = 1'b1;
    cycle();
    rd("rst_mem_kept_0x34", 32'h34, 32'h5A5A0000);
    rd("rst_mem_kept_0x30", 32'h30, 32'h77777777);
    cycle();

    // Randomized traffic; valids stay up with stable payload until accepted.
    for (int n = 0; n < 4000; n++) begin
      if (!axi_if.awvalid || aw_acc) begin
        axi_if.awvalid = ($urandom_range(0, 2) != 0);
        axi_if.awaddr  = rand_addr();
      end
      if (!axi_if.wvalid || w_acc) begin
        axi_if.wvalid = ($urandom_range(0, 2) != 0);
        axi_if.wdata  = $urandom;
        axi_if.wstrb  = 4'($urandom_range(0, 15));
      end
      if (!axi_if.arvalid || ar_acc) begin
        axi_if.arvalid = ($urandom_range(0, 1) != 0);
        axi_if.araddr  = rand_addr();
      end
      axi_if.bready = ($urandom_range(0, 3) != 0);
      axi_if.rready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rvee_dmem.md
RVEE_DMEM -- requirements
Module: rvee_dmem

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data width; only 32 supported.
REQ-003 SHALL have parameter DEPTH, default 1024, number of DWIDTH words; power of two.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port axi_if, axi4lite_if.slave_port; AW/W/B/AR/R channels, addresses AWIDTH, data DWIDTH, wstrb DWIDTH/8, resp 2 bits.
REQ-007 SHALL ignore awprot/arprot.

Function
REQ-008 SHALL act as a 32-bit AXI4-lite data-memory slave, the downstream target of the load/store unit's AXI master port.
REQ-009 SHALL decode word index as addr[$clog2(DEPTH)+1:2]; addr[1:0] ignored (master pre-aligns data and wstrb).
REQ-010 AW and W SHALL be accepted independently into one-entry holding registers: awready = !aw_held, wready = !w_held.
REQ-011 When aw_held && w_held && !bvalid, SHALL write bytes enabled by held wstrb in that cycle, clear both held flags, and set bvalid next edge.
REQ-012 Write latency: AW and W handshaked in the same cycle -> bvalid asserted exactly 2 edges later.
REQ-013 bvalid SHALL remain high with bresp stable until bready; new writes stall in holding registers while bvalid && !bready.
REQ-014 wstrb = 0 SHALL leave memory unchanged and still produce an OKAY response.
REQ-015 arready SHALL equal !rvalid || rready (one-deep read pipeline, full throughput when rready held high).
REQ-016 AR handshake SHALL register rdata = mem[index] and assert rvalid on the next edge; rdata/rresp stable until rready.
REQ-017 Same-edge read and write to the same word SHALL return pre-write (old) data.
REQ-018 Read and write channels SHALL be fully independent; neither blocks the other.
REQ-019 Aligned full-word read after completed write SHALL return written data with strobed byte lanes merged.

Reset
REQ-020 On rst_n low, asynchronously: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, held flags cleared.
REQ-021 Reset mid-transaction SHALL drop held AW/W and pending B/R without memory write; memory contents SHALL NOT be reset.
REQ-022 Outputs SHALL stay at reset values until the first rising edge after rst_n deasserts.

Configuration
REQ-023 Macro RVEE_CONFIG_DMEM_ERR_EN SHALL control out-of-range handling.
REQ-024 With RVEE_CONFIG_DMEM_ERR_EN defined: address with any bit set above bit $clog2(DEPTH)+1 SHALL give bresp/rresp = SLVERR (2'b10), suppress the write, return rdata = 0.
REQ-025 Without it: upper address bits ignored (address wraps modulo DEPTH*4), responses always OKAY (2'b00).

Verification
REQ-026 Write 0x100 data 0xDEADBEEF wstrb 4'hF, AW+W same cycle, bready=1 -> bvalid 2 edges later, bresp=0; read 0x100 -> rvalid 1 edge after AR, rdata=0xDEADBEEF.
REQ-027 W two cycles before AW at 0x104, data 0x11223344 wstrb 4'b0101 over prior 0xFFFFFFFF -> wready low after W, single B; read 0x104 -> 0xFF22FF44.
REQ-028 bready=0 for 5 cycles after write -> bvalid and bresp held; second AW/W accepted into holding regs then awready=wready=0; B for second only after first B handshake.
REQ-029 Back-to-back reads 0x0,0x4,0x8 with rready=1 -> arready constantly 1, rvalid 3 consecutive cycles, data in order; rready=0 -> arready=0 while rvalid held.
REQ-030 Same-edge write 0xA5A5A5A5 and read to 0x20 holding 0x0 -> read returns 0x0; next read returns 0xA5A5A5A5.
REQ-031 DEPTH=1024, read 0x1000: with RVEE_CONFIG_DMEM_ERR_EN rresp=2'b10 rdata=0; without, rresp=0, rdata=mem[0]; rst_n pulsed with bvalid high -> bvalid=0 immediately, memory unchanged.
